// File: rtl/sseg_scan.sv
// Scans four snapshotted digit patterns onto a shared active-low 4-digit display; outputs lag state by 1 cycle.
// No backpressure: free-running scan; inputs are sampled once per frame so a frame is never torn.
module sseg_scan #(
  parameter int REFRESH_COUNT = 50000,
  parameter int BLANK_COUNT   = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_0,
  input  logic [7:0] in_1,
  input  logic [7:0] in_2,
  input  logic [7:0] in_3,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int            CW        = $clog2(REFRESH_COUNT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_COUNT - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_COUNT);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [7:0]    snap [4];
  logic [7:0]    snap_sel;
  logic          slot_end;
  logic          frame_start;
  logic          in_blank;

  assign slot_end    = (cnt == CNT_LAST);
  assign frame_start = (cnt == '0) && (idx == 2'd0);
  assign in_blank    = (cnt < CNT_BLANK);
  assign snap_sel    = snap[idx];

  // Slot counter and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Whole-frame snapshot taken only at the (0,0) state so digits never mix frames
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        snap[k] <= 8'hFF;
      end
    end else if (frame_start) begin
      snap[0] <= in_0;
      snap[1] <= in_1;
      snap[2] <= in_2;
      snap[3] <= in_3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= 4'b1111;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      if (in_blank) begin
        an   <= 4'b1111;
        sseg <= 8'hFF;
      end else begin
        an   <= ~(4'b0001 << idx);
        sseg <= snap_sel;
      end
      // Registered one cycle ahead so the pulse coincides with the (0,0) state
      frame_tick <= slot_end && (idx == 2'd3);
    end
  end

endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan: main instance R=8,B=2 and a boundary instance R=2,B=1.
module tb_sseg_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset_b;
  logic [7:0] in_0, in_1, in_2, in_3;
  logic [7:0] bin_0, bin_1, bin_2, bin_3;
  logic [3:0] an, an_b;
  logic [7:0] sseg, sseg_b;
  logic       frame_tick, frame_tick_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  sseg_scan #(.REFRESH_COUNT(8), .BLANK_COUNT(2)) dut (
    .clk(clk), .reset(reset),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .an(an), .sseg(sseg), .frame_tick(frame_tick)
  );

  sseg_scan #(.REFRESH_COUNT(2), .BLANK_COUNT(1)) dut_b (
    .clk(clk), .reset(reset_b),
    .in_0(bin_0), .in_1(bin_1), .in_2(bin_2), .in_3(bin_3),
    .an(an_b), .sseg(sseg_b), .frame_tick(frame_tick_b)
  );

  // Digit shown in cycle n (cycle 0 = first cycle with reset low), or -1 if blank:
  // digit k is blank in kR+1..kR+B and active in kR+B+1..(k+1)R, period 4R.
  function automatic int exp_digit(int n, int r, int b);
    int m;
    if (n <= 0) return -1;
    m = (n - 1) % r;
    if (m < b) return -1;
    return ((n - 1) / r) % 4;
  endfunction

  function automatic logic [3:0] an_of(int d);
    if (d < 0) return 4'b1111;
    return ~(4'b0001 << d);
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Two rising edges with reset high; returns at the negedge inside cycle 0.
  task automatic reset_a();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic set_static();
    in_0 = 8'hC0; in_1 = 8'hF9; in_2 = 8'hA4; in_3 = 8'hB0;
  endtask

  task automatic test_reset();
    set_static();
    reset_a();
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
    checks++; if (sseg !== 8'hFF) begin failures++; $display("FAIL reset_sseg got=%h exp=ff", sseg); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    checks++; if (an_b !== 4'b1111) begin failures++; $display("FAIL reset_b_an got=%b exp=1111", an_b); end
    checks++; if (sseg_b !== 8'hFF) begin failures++; $display("FAIL reset_b_sseg got=%h exp=ff", sseg_b); end
    checks++; if (frame_tick_b !== 1'b0) begin failures++; $display("FAIL reset_b_tick got=%b exp=0", frame_tick_b); end
  endtask

  task automatic test_static();
    logic [7:0] pat [4];
    int d;
    logic [3:0] ea;
    logic [7:0] es;
    logic et;
    pat[0] = 8'hC0; pat[1] = 8'hF9; pat[2] = 8'hA4; pat[3] = 8'hB0;
    set_static();
    reset_a();
    for (int n = 0; n <= 100; n++) begin
      d  = exp_digit(n, 8, 2);
      ea = an_of(d);
      es = (d < 0) ? 8'hFF : pat[d];
      et = (n > 0) && (n % 32 == 0);
      checks++; if (an !== ea) begin failures++; $display("FAIL static_an cyc=%0d got=%b exp=%b", cyc, an, ea); end
      checks++; if (sseg !== es) begin failures++; $display("FAIL static_sseg cyc=%0d got=%h exp=%h", cyc, sseg, es); end
      checks++; if (frame_tick !== et) begin failures++; $display("FAIL static_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, et); end
      step();
    end
  endtask

  task automatic test_tear_free();
    logic [7:0] pat [4];
    int d;
    logic [7:0] es;
    pat[1] = 8'hF9; pat[2] = 8'hA4; pat[3] = 8'hB0;
    set_static();
    reset_a();
    for (int n = 0; n <= 40; n++) begin
      // Snapshot reloads only at cycle 32, so digit 0 shows 92 from its next active slot
      pat[0] = (n > 32) ? 8'h92 : 8'hC0;
      d  = exp_digit(n, 8, 2);
      es = (d < 0) ? 8'hFF : pat[d];
      checks++; if (an !== an_of(d)) begin failures++; $display("FAIL tear_an cyc=%0d got=%b exp=%b", cyc, an, an_of(d)); end
      checks++; if (sseg !== es) begin failures++; $display("FAIL tear_sseg cyc=%0d got=%h exp=%h", cyc, sseg, es); end
      if (n == 5) in_0 = 8'h92;
      step();
    end
  endtask

  task automatic test_invariants();
    int zeros;
    set_static();
    reset_a();
    for (int n = 0; n < 200; n++) begin
      zeros = $countones(~an);
      checks++; if (zeros > 1) begin failures++; $display("FAIL onehot_an cyc=%0d got=%b exp=at_most_one_zero", cyc, an); end
      checks++;
      if (an === 4'b1111 && sseg !== 8'hFF) begin
        failures++; $display("FAIL blank_sseg cyc=%0d got=%h exp=ff", cyc, sseg);
      end
      in_0 = 8'($urandom); in_1 = 8'($urandom); in_2 = 8'($urandom); in_3 = 8'($urandom);
      step();
    end
  endtask

  task automatic test_mid_reset();
    set_static();
    reset_a();
    repeat (20) step();
    checks++; if (an !== 4'b1011 || sseg !== 8'hA4) begin failures++; $display("FAIL midrst_pre cyc=%0d got=%b/%h exp=1011/a4", cyc, an, sseg); end
    reset = 1'b1;
    in_0  = 8'h88;
    step();
    reset = 1'b0;
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL midrst_an got=%b exp=1111", an); end
    checks++; if (sseg !== 8'hFF) begin failures++; $display("FAIL midrst_sseg got=%h exp=ff", sseg); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL midrst_tick got=%b exp=0", frame_tick); end
    step();
    in_0 = 8'h00;
    for (int n = 22; n <= 29; n++) begin
      if (n <= 23) begin
        checks++; if (an !== 4'b1111 || sseg !== 8'hFF) begin failures++; $display("FAIL midrst_blank cyc=%0d got=%b/%h exp=1111/ff", cyc, an, sseg); end
      end else begin
        checks++; if (an !== 4'b1110 || sseg !== 8'h88) begin failures++; $display("FAIL midrst_d0 cyc=%0d got=%b/%h exp=1110/88", cyc, an, sseg); end
      end
      step();
    end
  endtask

  task automatic test_boundary();
    logic [7:0] pat [4];
    int d;
    logic [3:0] ea;
    logic [7:0] es;
    logic et;
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h44; pat[3] = 8'h88;
    bin_0 = 8'h11; bin_1 = 8'h22; bin_2 = 8'h44; bin_3 = 8'h88;
    @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    for (int n = 0; n <= 24; n++) begin
      // Odd cycles blank, even cycles >= 2 show digits 0,1,2,3 in turn
      d  = (n >= 2 && n % 2 == 0) ? ((n - 2) / 2) % 4 : -1;
      ea = an_of(d);
      es = (d < 0) ? 8'hFF : pat[d];
      et = (n > 0) && (n % 8 == 0);
      checks++; if (an_b !== ea) begin failures++; $display("FAIL bound_an n=%0d got=%b exp=%b", n, an_b, ea); end
      checks++; if (sseg_b !== es) begin failures++; $display("FAIL bound_sseg n=%0d got=%h exp=%h", n, sseg_b, es); end
      checks++; if (frame_tick_b !== et) begin failures++; $display("FAIL bound_tick n=%0d got=%b exp=%b", n, frame_tick_b, et); end
      @(negedge clk);
    end
  endtask

  initial begin
    reset   = 1'b1;
    reset_b = 1'b1;
    in_0 = 8'hFF; in_1 = 8'hFF; in_2 = 8'hFF; in_3 = 8'hFF;
    bin_0 = 8'hFF; bin_1 = 8'hFF; bin_2 = 8'hFF; bin_3 = 8'hFF;
    test_reset();
    test_static();
    test_tear_free();
    test_invariants();
    test_mid_reset();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
